// File: rtl/led_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : led_ctrl (with helper led_ctrl_debounce)                   |
// | Purpose  : Mode controller for a 2-bit LED output stage. Synchronizes |
// |            and debounces a 4-bit switch bank and a mode button, then  |
// |            drives the LEDs in DECODE / BLINK / LAMP / OFF modes, plus |
// |            a free-running heartbeat blink.                            |
// | Options  : LED_CTRL_ACTIVE_LOW_EN - invert led and blink at the       |
// |            output register (reset led=11, blink=1, OFF drives 11).    |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+

// Two-flop synchronizer followed by a stable-count debouncer.
module led_ctrl_debounce #(
  parameter int WIDTH      = 1,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);

  localparam int              CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] meta_q, meta_d;
  logic [WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Candidate tracks the synced input; any change restarts the stability count.
  always_comb begin
    meta_d   = raw;
    sync_d   = meta_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync_q != cand_q) begin
      cand_d = sync_q;
      cnt_d  = '0;
    end else if (cand_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = cand_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, candidate, counter and stable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable = stable_q;

endmodule

module led_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int BLINK_DIV  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s,
  input  logic       mode_btn,
  output logic [1:0] led,
  output logic       blink,
  output logic [1:0] mode
);

`ifdef LED_CTRL_ACTIVE_LOW_EN
  localparam logic OUT_INV = 1'b1;
`else
  localparam logic OUT_INV = 1'b0;
`endif

  localparam int               PRE_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_DECODE = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_LAMP   = 2'b10,
    MODE_OFF    = 2'b11
  } mode_e;

  logic [3:0] s_stable;
  logic       btn_stable;

  led_ctrl_debounce #(.WIDTH(4), .DEB_CYCLES(DEB_CYCLES)) u_deb_s (
    .clk    (clk),
    .reset  (reset),
    .raw    (s),
    .stable (s_stable)
  );

  led_ctrl_debounce #(.WIDTH(1), .DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
    .clk    (clk),
    .reset  (reset),
    .raw    (mode_btn),
    .stable (btn_stable)
  );

  mode_e            mode_q, mode_d;
  logic             btn_prev_q, btn_prev_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [1:0]       lamp_idx_q, lamp_idx_d;
  logic             blink_q, blink_d;
  logic [1:0]       led_q, led_d;
  logic             tick;
  logic             blink_true_next;
  logic [1:0]       led_true;

  // Next-state: mode sequencing, prescaler, heartbeat, lamp walk and LED decode.
  always_comb begin
    btn_prev_d = btn_stable;
    mode_d     = mode_q;
    if (btn_stable && !btn_prev_q) begin
      case (mode_q)
        MODE_DECODE: mode_d = MODE_BLINK;
        MODE_BLINK:  mode_d = MODE_LAMP;
        MODE_LAMP:   mode_d = MODE_OFF;
        default:     mode_d = MODE_DECODE;
      endcase
    end

    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + 1'b1;

    // blink_q holds the output polarity; a toggle is polarity-agnostic.
    blink_d         = tick ? ~blink_q : blink_q;
    blink_true_next = blink_d ^ OUT_INV;

    // Entering LAMP restarts the walk and swallows a coincident tick.
    lamp_idx_d = lamp_idx_q;
    if (mode_d == MODE_LAMP && mode_q != MODE_LAMP) begin
      lamp_idx_d = 2'd0;
    end else if (mode_d == MODE_LAMP && tick) begin
      lamp_idx_d = lamp_idx_q + 2'd1;
    end

    case (mode_q)
      MODE_DECODE: led_true = {s_stable[3] & s_stable[2], s_stable[1] ^ s_stable[0]};
      MODE_BLINK:  led_true = {blink_true_next, ~blink_true_next};
      MODE_LAMP:   led_true = lamp_idx_q + 2'd1;  // 0..3 -> 01,10,11,00
      default:     led_true = 2'b00;
    endcase
    led_d = led_true ^ {2{OUT_INV}};
  end

  // Mode FSM state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE_DECODE;
      btn_prev_q <= 1'b0;
      pre_q      <= '0;
      lamp_idx_q <= 2'd0;
      blink_q    <= OUT_INV;
      led_q      <= {2{OUT_INV}};
    end else begin
      mode_q     <= mode_d;
      btn_prev_q <= btn_prev_d;
      pre_q      <= pre_d;
      lamp_idx_q <= lamp_idx_d;
      blink_q    <= blink_d;
      led_q      <= led_d;
    end
  end

  assign led   = led_q;
  assign blink = blink_q;
  assign mode  = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_led_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module   : tb_led_ctrl                                                |
// | Purpose  : Scoreboard bench for led_ctrl. Stimulus queues expected    |
// |            led/mode/blink per clock edge; a monitor compares them.    |
// |            Honours LED_CTRL_ACTIVE_LOW_EN for output polarity.        |
// | Revision : 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_led_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 8;
`ifdef LED_CTRL_ACTIVE_LOW_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s;
  logic       mode_btn;
  logic [1:0] led;
  logic       blink;
  logic [1:0] mode;

  led_ctrl #(.DEB_CYCLES(DEB), .BLINK_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .s        (s),
    .mode_btn (mode_btn),
    .led      (led),
    .blink    (blink),
    .mode     (mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] led;
    logic [1:0] mode;
    logic       blink;
    bit         cl;
    bit         cm;
    bit         cb;
    string      nm;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   cyc   = 0;
  int   base  = 0;
  int   total = 0;
  int   bad   = 0;

  logic [1:0] lamp_map [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] lv(input logic [1:0] x);
    return x ^ {2{INV}};
  endfunction

  // Heartbeat model: toggles on every DIV-th edge after reset release.
  function automatic logic bexp(input int at);
    return ((((at - base) / DIV) % 2) == 1) ^ INV;
  endfunction

  task automatic push(input int at, input logic [1:0] l, input logic [1:0] m,
                      input bit cl, input bit cm, input string nm);
    exp_t x;
    x.cyc = at; x.led = l; x.mode = m; x.blink = bexp(at);
    x.cl = cl; x.cm = cm; x.cb = 1'b1; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic push_rst(input int at, input string nm);
    exp_t x;
    x.cyc = at; x.led = lv(2'b00); x.mode = 2'b00; x.blink = INV;
    x.cl = 1'b1; x.cm = 1'b1; x.cb = 1'b1; x.nm = nm;
    sb.push_back(x);
  endtask

  // Monitor: pop every expectation due at this edge and compare.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.cyc < cyc) begin
        total++; bad++;
        $display("FAIL %s: check for edge %0d skipped, now edge %0d", e.nm, e.cyc, cyc);
      end else begin
        if (e.cl) begin
          total++;
          if (led !== e.led) begin
            bad++;
            $display("FAIL %s led @%0d: got %b want %b", e.nm, cyc, led, e.led);
          end
        end
        if (e.cm) begin
          total++;
          if (mode !== e.mode) begin
            bad++;
            $display("FAIL %s mode @%0d: got %b want %b", e.nm, cyc, mode, e.mode);
          end
        end
        if (e.cb) begin
          total++;
          if (blink !== e.blink) begin
            bad++;
            $display("FAIL %s blink @%0d: got %b want %b", e.nm, cyc, blink, e.blink);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, pending=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int   t;
    int   ent;
    int   idx;
    logic bt;

    reset = 1'b1; s = 4'b0000; mode_btn = 1'b0;
    repeat (2) @(negedge clk);
    push_rst(cyc + 1, "reset");
    @(negedge clk);

    // Clean step to 1111: led 10 exactly 8 edges later.
    reset = 1'b0; base = cyc; s = 4'b1111;
    for (int k = 1; k <= 10; k++)
      push(base + k, lv(k < 8 ? 2'b00 : 2'b10), 2'b00, 1'b1, 1'b1, "t1_step");
    repeat (12) @(negedge clk);

    // 0001 with a one-cycle glitch to 0000 on the third sample.
    t = cyc;
    for (int k = 1; k <= 12; k++)
      push(t + k, lv(k < 11 ? 2'b10 : 2'b01), 2'b00, 1'b1, 1'b1, "t2_glitch");
    s = 4'b0001;
    repeat (2) @(negedge clk);
    s = 4'b0000;
    @(negedge clk);
    s = 4'b0001;
    repeat (10) @(negedge clk);

    // Four 10-cycle presses, 20-cycle gaps: mode 01,10,11,00.
    t = cyc;
    push(t + 7,  2'b00, 2'b00, 1'b0, 1'b1, "t3_p0_pre");
    push(t + 8,  2'b00, 2'b01, 1'b0, 1'b1, "t3_p0");
    push(t + 37, 2'b00, 2'b01, 1'b0, 1'b1, "t3_p1_pre");
    push(t + 38, 2'b00, 2'b10, 1'b0, 1'b1, "t3_p1");
    push(t + 67, 2'b00, 2'b10, 1'b0, 1'b1, "t3_p2_pre");
    push(t + 68, 2'b00, 2'b11, 1'b0, 1'b1, "t3_p2");
    push(t + 69, lv(2'b00), 2'b11, 1'b1, 1'b1, "t3_off");
    push(t + 97, lv(2'b00), 2'b11, 1'b1, 1'b1, "t3_off_end");
    push(t + 98, lv(2'b00), 2'b00, 1'b1, 1'b1, "t3_p3");
    push(t + 99, lv(2'b01), 2'b00, 1'b1, 1'b1, "t3_redecode");
    for (int p = 0; p < 4; p++) begin
      mode_btn = 1'b1;
      repeat (10) @(negedge clk);
      mode_btn = 1'b0;
      repeat (20) @(negedge clk);
    end

    // 30-cycle hold: exactly one advance to BLINK.
    t = cyc;
    push(t + 7,  2'b00, 2'b00, 1'b0, 1'b1, "t3_hold_pre");
    push(t + 8,  2'b00, 2'b01, 1'b0, 1'b1, "t3_hold");
    push(t + 35, 2'b00, 2'b01, 1'b0, 1'b1, "t3_hold_mid");
    push(t + 45, 2'b00, 2'b01, 1'b0, 1'b1, "t3_hold_end");
    mode_btn = 1'b1;
    repeat (30) @(negedge clk);
    mode_btn = 1'b0;
    repeat (20) @(negedge clk);

    // BLINK for 64 cycles: led alternates in phase with blink.
    t = cyc;
    for (int k = 1; k <= 64; k++) begin
      bt = (((t + k - base) / DIV) % 2) == 1;
      push(t + k, lv({bt, ~bt}), 2'b01, 1'b1, 1'b1, "t4_blink");
    end
    repeat (66) @(negedge clk);

    // Enter LAMP: walk 01,10,11,00,01 one edge after each tick.
    t   = cyc;
    ent = t + 8;
    push(ent - 1, 2'b00, 2'b01, 1'b0, 1'b1, "t5_pre");
    push(ent,     2'b00, 2'b10, 1'b0, 1'b1, "t5_enter");
    idx = 0;
    for (int ed = ent + 1; ed <= ent + 34; ed++) begin
      push(ed, lv(lamp_map[idx]), 2'b10, 1'b1, 1'b1, "t5_lamp");
      if (((ed - base) % DIV) == 0) idx = (idx + 1) % 4;
    end
    mode_btn = 1'b1;
    repeat (10) @(negedge clk);
    mode_btn = 1'b0;
    repeat (32) @(negedge clk);

    // Reset mid-walk, then the held 0001 re-emerges after a full latency.
    reset = 1'b1;
    push_rst(cyc + 1, "t5_reset");
    @(negedge clk);
    reset = 1'b0; base = cyc;
    for (int k = 1; k <= 9; k++)
      push(base + k, lv(k < 8 ? 2'b00 : 2'b01), 2'b00, 1'b1, 1'b1, "t6_after_rst");
    repeat (10) @(negedge clk);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d expectations never checked", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
- Mode controller for the lab's 2-bit LED output stage.
- Takes the raw 4-bit switch bank and a mode pushbutton, and synchronizes and debounces both.
- Sequences the LED pair through four display modes: switch decode, alternating blink, lamp-test walk, and off.
- Also drives a free-running heartbeat blink output from an internal prescaler.

Parameters:
- DEB_CYCLES, 4: consecutive stable cycles required before a debounced input updates; legal range 1..65535.
- BLINK_DIV, 8: clock cycles per prescaler tick; legal range 2..2^24. Board build uses 12_000_000.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- s  input  4  raw switch inputs, asynchronous to clk
- mode_btn  input  1  raw mode pushbutton, asynchronous, active-high
- led  output  2  registered LED drive
- blink  output  1  registered heartbeat, toggles once per prescaler tick
- mode  output  2  current mode state: 00 DECODE, 01 BLINK, 10 LAMP, 11 OFF

Behaviour:
- Reset: clk and reset only; reset is synchronous and active-high, sampled on the rising edge. On reset:
  - led=00, blink=0, mode=00 (DECODE).
  - Prescaler=0, lamp index=0.
  - Synchronizer flops, debounce candidates, counters and s_stable/btn_stable all =0.
  - Reset mid-operation takes effect on the next rising edge, with no partial state retained.
- Synchronizer: two flops per bit on s and mode_btn.
- Debounce: one instance for the s vector, one for mode_btn.
  - If synced value != candidate: candidate<=synced, count<=0.
  - Else if candidate != stable: if count==DEB_CYCLES-1, stable<=candidate; else count++.
  - Any mid-count glitch restarts the count.
- Latency: a clean step on s reaches led in DECODE exactly DEB_CYCLES+4 rising edges after it (2 sync + candidate + DEB_CYCLES count + output register).
- Mode FSM: rising edge of btn_stable (btn_stable=1 while previous value=0) advances the mode.
  - Sequence: DECODE -> BLINK -> LAMP -> OFF -> DECODE (wraps).
  - Exactly one advance per press; holding the button produces no further advances.
  - mode output updates on the same edge the FSM state does.
- Prescaler:
  - Counts 0..BLINK_DIV-1 and wraps.
  - tick is asserted internally for one cycle when count==BLINK_DIV-1.
  - Runs in every mode and is never reset by a mode change.
- blink toggles on every tick, in all modes.
- led, registered one cycle after the mode/state it reflects:
  - DECODE: led[0]=s_stable[1]^s_stable[0]; led[1]=s_stable[3]&s_stable[2].
  - BLINK: led={blink_next, ~blink_next}, where blink_next is the value blink takes on that edge. The LEDs therefore alternate in phase with blink.
  - LAMP: led follows lamp index 0..3, mapped to 01, 10, 11, 00. Index advances on tick and wraps 3->0. Index is cleared to 0 on the edge that enters LAMP.
  - OFF: led=00.
- Simultaneous events: a tick coinciding with a mode advance uses the new mode. On entering LAMP, the index stays 0 for that edge and the tick is consumed without advancing.
- A switch change during non-DECODE modes still updates s_stable. The new value shows on led on the edge after DECODE is re-entered.

Optional Feature:
- Macro: LED_CTRL_ACTIVE_LOW_EN
- Defined: led and blink are inverted at the output register. Reset values become led=11, blink=1, and OFF mode drives 11. The mode port is unaffected.
- Undefined: active-high outputs as specified above.

Test Plan (DEB_CYCLES=4, BLINK_DIV=8 unless noted):
- Reset then s=4'b1111 held clean -> led=00 until edge 8 after the change, then led=2'b10; mode=00, blink=0 throughout the first 8 cycles after reset.
- s=4'b0001 with a 1-cycle glitch to 4'b0000 at cycle 3 -> no intermediate led value; led=2'b01 exactly 8 edges after the glitch clears.
- mode_btn pulsed high 10 cycles, 4 times, with 20-cycle gaps -> mode steps 01, 10, 11, 00. A 30-cycle hold produces only one advance.
- Mode BLINK for 64 cycles -> blink toggles every 8 cycles; led alternates 01/10 with led[1]==blink after each toggle.
- Enter LAMP -> led=01 on the entry-following edge, then 10, 11, 00, 01 at successive ticks. Reset asserted mid-walk -> led=00, mode=00 on the next edge.
- Compile with LED_CTRL_ACTIVE_LOW_EN, repeat test 1 -> reset led=11, blink=1; final led=2'b01.
